// File: rtl/wptr_full_sync.sv
// Write-side pointer and full/almost-full/occupancy logic of an async FIFO.
// Optional sticky overflow flag enabled by defining WPTR_FULL_OVF_EN.
module wptr_full_sync #(
  parameter int unsigned PTR_WIDTH    = 5,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned AFULL_THRESH = 28
) (
  input  logic                 wr_clk_i,
  input  logic                 rstn_i,
  input  logic                 wr_en_i,
  input  logic [PTR_WIDTH:0]   rptr_gray_i,
  input  logic                 ovf_clr_i,
  output logic                 wr_accept_o,
  output logic [PTR_WIDTH-1:0] wr_addr_o,
  output logic [PTR_WIDTH:0]   wptr_gray_o,
  output logic [PTR_WIDTH:0]   wptr_bin_o,
  output logic                 wr_full_o,
  output logic                 wr_afull_o,
  output logic [PTR_WIDTH:0]   wr_cnt_o,
  output logic                 wr_ovf_o
);

  localparam int unsigned   PW        = PTR_WIDTH + 1;
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);
  localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] rptr_sync;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] cnt_next;
  logic          full_next;
  logic          afull_next;

  // Read-pointer synchroniser chain
  always_ff @(posedge wr_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= rptr_gray_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign rptr_sync = sync_q[SYNC_STAGES-1];

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
  always_comb begin
    rbin_s = '0;
    for (int unsigned i = 0; i < PW; i++) rbin_s[i] = ^(rptr_sync >> i);
  end

  assign wr_accept_o = wr_en_i & ~wr_full_o;
  assign wr_addr_o   = wptr_bin_o[PTR_WIDTH-1:0];

  // Next pointer and flags, evaluated against the current synchronised read pointer
  always_comb begin
    wbin_next  = wptr_bin_o + PW'(wr_accept_o);
    wgray_next = wbin_next ^ (wbin_next >> 1);
    full_next  = (rptr_sync == (wgray_next ^ FULL_MASK));
    cnt_next   = wbin_next - rbin_s;
    afull_next = (cnt_next >= AFULL_LVL);
  end

  always_ff @(posedge wr_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr_bin_o  <= '0;
      wptr_gray_o <= '0;
      wr_full_o   <= 1'b0;
      wr_afull_o  <= 1'b0;
      wr_cnt_o    <= '0;
    end else begin
      wptr_bin_o  <= wbin_next;
      wptr_gray_o <= wgray_next;
      wr_full_o   <= full_next;
      wr_afull_o  <= afull_next;
      wr_cnt_o    <= cnt_next;
    end
  end

`ifdef WPTR_FULL_OVF_EN
  // Sticky overflow; a new overflow wins over a simultaneous clear
  always_ff @(posedge wr_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ovf_o <= 1'b0;
    end else if (wr_en_i && wr_full_o) begin
      wr_ovf_o <= 1'b1;
    end else if (ovf_clr_i) begin
      wr_ovf_o <= 1'b0;
    end
  end
`else
  // Overflow tracking compiled out; the clear input has no effect
  assign wr_ovf_o = 1'b0 & ovf_clr_i;
`endif

endmodule
